// File: rtl/omem_writeback.sv
// omem_writeback
//   Output-memory write-back stage. Each accepted 4-lane partial-sum row is
//   either written as-is or added into the stored word. This happens through a
//   two-stage read-modify-write on a 1R1W RAM: stage 0 issues the read and
//   stage 1 issues the write. A 1-cycle Tile_Done pulse follows the last row
//   of each tile. A CLR pulse zero-fills the whole RAM, one word per cycle.
//
// Ports
//   CLK, RSTN           clock, synchronous active-low reset
//   CLR                 pulse: start zero-clear of all 2^AW words
//   ROWS                rows per tile (1..4, 0 or >4 means 4); sampled with
//                       the first row of a tile
//   PSUM_VALID/DATA     partial-sum row; lane i at [i*PW +: PW]
//   ODST, ACC           destination word; 1 = accumulate, 0 = overwrite
//   OM_REN/RADDR/RDATA  RAM read port (RDATA valid one cycle after REN)
//   OM_WEN/WADDR/WDATA  RAM write port
//   BUSY                high while clearing
//   Tile_Done           1-cycle pulse after the last row of a tile is written
//   ERR                 sticky: a row was dropped (during clear or in CLR cycle)
//   DBG_STATE           FSM state (0 = IDLE, 1 = CLEAR)
//
// Handshake: there is no back-pressure. A row is taken whenever PSUM_VALID=1
// in IDLE without CLR in the same cycle. Otherwise the row is lost and ERR
// is raised.
module omem_writeback #(
  parameter int PW    = 16,
  parameter int LANES = 4,
  parameter int AW    = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  CLR,
  input  logic [2:0]            ROWS,
  input  logic                  PSUM_VALID,
  input  logic [LANES*PW-1:0]   PSUM_DATA,
  input  logic [AW-1:0]         ODST,
  input  logic                  ACC,
  output logic                  OM_REN,
  output logic [AW-1:0]         OM_RADDR,
  input  logic [LANES*PW-1:0]   OM_RDATA,
  output logic                  OM_WEN,
  output logic [AW-1:0]         OM_WADDR,
  output logic [LANES*PW-1:0]   OM_WDATA,
  output logic                  BUSY,
  output logic                  Tile_Done,
  output logic                  ERR,
  output logic                  DBG_STATE
);

  localparam int W = LANES * PW;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_addr_q;

  logic            s1_valid_q;
  logic [AW-1:0]   s1_addr_q;
  logic [W-1:0]    s1_data_q;
  logic            s1_acc_q;
  logic            s1_fwd_q;
  logic [W-1:0]    fwd_data_q;

  logic [1:0]      cnt_q;
  logic [2:0]      rows_eff_q;
  logic            td_q;
  logic            err_q;

  logic            clr_go, accept, drop, ren, fwd_hit;
  logic [W-1:0]    old_data, s1_wdata;
  logic [2:0]      rows_in;
  logic            last_wr;
  logic [1:0]      cnt_after;
  logic            first_row;
  logic            wen_int;
  logic [AW-1:0]   waddr_int;
  logic [W-1:0]    wdata_int;

  // ---------------- acceptance / stage 0 ----------------
  always_comb begin
    clr_go  = CLR && (state_q == S_IDLE);
    accept  = PSUM_VALID && (state_q == S_IDLE) && !CLR;
    drop    = PSUM_VALID && !accept;
    ren     = accept && ACC;
    // The RAM returns pre-write data when reading the word stage 1 is
    // writing this cycle, so the write data is forwarded instead.
    fwd_hit = ren && s1_valid_q && (s1_addr_q == ODST);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLK) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clr_go) state_d = S_CLEAR;
      S_CLEAR: if (clr_addr_q == LAST_ADDR) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Clear address sits at 0 in IDLE and wraps back to 0 after the last word.
  always_ff @(posedge CLK) begin
    if (!RSTN)                   clr_addr_q <= '0;
    else if (state_q == S_CLEAR) clr_addr_q <= clr_addr_q + 1'b1;
  end

  // ---------------- stage 1 ----------------
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_acc_q   <= 1'b0;
      s1_fwd_q   <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= ODST;
        s1_data_q <= PSUM_DATA;
        s1_acc_q  <= ACC;
        s1_fwd_q  <= fwd_hit;
      end
      if (fwd_hit) fwd_data_q <= s1_wdata;
    end
  end

  // Lane-wise modular add; no saturation.
  always_comb begin
    old_data = s1_fwd_q ? fwd_data_q : OM_RDATA;
    s1_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_wdata[i*PW +: PW] = s1_acc_q ? (old_data[i*PW +: PW] + s1_data_q[i*PW +: PW])
                                      : s1_data_q[i*PW +: PW];
    end
  end

  // ---------------- row counter / tile done ----------------
  always_comb begin
    rows_in = ((ROWS == 3'd0) || (ROWS > 3'd4)) ? 3'd4 : ROWS;
    last_wr = s1_valid_q && ({1'b0, cnt_q} == (rows_eff_q - 3'd1));
    if (!s1_valid_q)  cnt_after = cnt_q;
    else if (last_wr) cnt_after = 2'd0;
    else              cnt_after = cnt_q + 2'd1;
    // The counter lags acceptance by one cycle. The first-row test therefore
    // uses the count after this cycle's stage-1 write, so that back-to-back
    // tiles latch ROWS on their own first row.
    first_row = accept && (cnt_after == 2'd0);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cnt_q      <= 2'd0;
      rows_eff_q <= 3'd4;
      td_q       <= 1'b0;
    end else begin
      cnt_q <= clr_go ? 2'd0 : cnt_after;
      if (first_row) rows_eff_q <= rows_in;
      td_q <= last_wr;
    end
  end

  // ---------------- error flag ----------------
  // A row arriving with the accepted CLR sets ERR again after the clear.
  always_ff @(posedge CLK) begin
    if (!RSTN) err_q <= 1'b0;
    else begin
      if (clr_go) err_q <= 1'b0;
      if (drop)   err_q <= 1'b1;
    end
  end

  // ---------------- write port ----------------
  // Stage 1 owns the port when occupied. Clear writes take it otherwise.
  always_comb begin
    wen_int   = s1_valid_q || (state_q == S_CLEAR);
    waddr_int = s1_valid_q ? s1_addr_q : clr_addr_q;
    wdata_int = s1_valid_q ? s1_wdata : '0;
  end

  // Outputs are forced low while RSTN is low. This suppresses an in-flight
  // write and a pending Tile_Done.
  always_comb begin
    OM_REN    = RSTN && ren;
    OM_RADDR  = OM_REN ? ODST : '0;
    OM_WEN    = RSTN && wen_int;
    OM_WADDR  = OM_WEN ? waddr_int : '0;
    OM_WDATA  = OM_WEN ? wdata_int : '0;
    BUSY      = RSTN && (state_q == S_CLEAR);
    Tile_Done = RSTN && td_q;
    ERR       = RSTN && err_q;
    DBG_STATE = RSTN && (state_q == S_CLEAR);
  end

endmodule

// File: tb/tb_omem_writeback.sv
// Testbench for omem_writeback: directed rows against a behavioural 1R1W RAM.
// Expected writes and Tile_Done cycles are queued at issue time. A negedge
// monitor pops and compares them whenever the DUT writes or pulses Tile_Done.
module tb_omem_writeback;

  localparam int PW = 16;
  localparam int LANES = 4;
  localparam int AW = 4;
  localparam int W = LANES * PW;

  logic           CLK = 1'b0;
  logic           RSTN = 1'b0;
  logic           CLR = 1'b0;
  logic [2:0]     ROWS = 3'd4;
  logic           PSUM_VALID = 1'b0;
  logic [W-1:0]   PSUM_DATA = '0;
  logic [AW-1:0]  ODST = '0;
  logic           ACC = 1'b0;
  logic           OM_REN;
  logic [AW-1:0]  OM_RADDR;
  logic [W-1:0]   OM_RDATA;
  logic           OM_WEN;
  logic [AW-1:0]  OM_WADDR;
  logic [W-1:0]   OM_WDATA;
  logic           BUSY, Tile_Done, ERR, DBG_STATE;

  omem_writeback #(.PW(PW), .LANES(LANES), .AW(AW)) dut (
    .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .ROWS(ROWS),
    .PSUM_VALID(PSUM_VALID), .PSUM_DATA(PSUM_DATA), .ODST(ODST), .ACC(ACC),
    .OM_REN(OM_REN), .OM_RADDR(OM_RADDR), .OM_RDATA(OM_RDATA),
    .OM_WEN(OM_WEN), .OM_WADDR(OM_WADDR), .OM_WDATA(OM_WDATA),
    .BUSY(BUSY), .Tile_Done(Tile_Done), .ERR(ERR), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / cycle count ----------------
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- RAM model (read returns pre-write data) ----------------
  logic [W-1:0] mem [2**AW];
  always @(posedge CLK) begin
    if (OM_WEN) mem[OM_WADDR] <= OM_WDATA;
    if (OM_REN) OM_RDATA <= mem[OM_RADDR];
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail = 0;
  logic [AW+W-1:0] exp_q[$];
  logic [31:0]     td_q[$];
  logic [W-1:0]    ref_mem [2**AW];
  int tb_cnt = 0;
  int tb_rows = 4;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [W-1:0] add_rows(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*PW +: PW] = a[i*PW +: PW] + b[i*PW +: PW];
    return r;
  endfunction

  // Monitor: compare every write and every Tile_Done against the queues.
  always @(negedge CLK) begin
    if (OM_WEN === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write (cycle %0d)",
                 OM_WADDR, OM_WDATA, cyc);
      end else begin
        check("write", 128'({OM_WADDR, OM_WDATA}), 128'(exp_q.pop_front()));
      end
    end
    if (Tile_Done === 1'b1) begin
      if (td_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_tile_done: got pulse at cycle %0d, required none", cyc);
      end else begin
        check("tile_done_cycle", 128'(cyc), 128'(td_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one row for one cycle. The expected write is use_exp ? exp_data : model.
  task automatic send_row(input logic [AW-1:0] addr, input logic [W-1:0] data, input logic acc,
                          input logic [2:0] rows, input logic use_exp, input logic [W-1:0] exp_data);
    logic [W-1:0] nv;
    nv = acc ? add_rows(ref_mem[addr], data) : data;
    if (use_exp) nv = exp_data;
    ref_mem[addr] = nv;
    exp_q.push_back({addr, nv});
    if (tb_cnt == 0) tb_rows = (rows == 3'd0 || rows > 3'd4) ? 4 : int'(rows);
    if (tb_cnt == tb_rows - 1) begin
      td_q.push_back(32'(cyc + 2));
      tb_cnt = 0;
    end else begin
      tb_cnt++;
    end
    PSUM_VALID = 1'b1; PSUM_DATA = data; ODST = addr; ACC = acc; ROWS = rows;
    @(negedge CLK);
    check("ren", 128'({OM_REN, OM_RADDR}), 128'({acc, acc ? addr : 4'd0}));
    @(posedge CLK); #1;
    PSUM_VALID = 1'b0; ACC = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Pulse CLR and check BUSY over the 16 clear cycles and right after.
  // row_in_clr drives a row with CLR. row_during drives rows in the first
  // two clear cycles.
  task automatic do_clr(input bit row_in_clr, input bit row_during);
    CLR = 1'b1; PSUM_VALID = row_in_clr; ACC = 1'b0; ODST = 4'd4;
    for (int j = 0; j < 2**AW; j++) begin
      exp_q.push_back({4'(j), {W{1'b0}}});
      ref_mem[j] = '0;
    end
    tb_cnt = 0;
    @(posedge CLK); #1;
    CLR = 1'b0;
    for (int j = 0; j < 2**AW; j++) begin
      PSUM_VALID = row_during && (j < 2);
      @(negedge CLK);
      check("busy_high", 128'({BUSY, DBG_STATE}), 128'(2'b11));
      @(posedge CLK); #1;
    end
    PSUM_VALID = 1'b0;
    @(negedge CLK);
    check("busy_low", 128'({BUSY, DBG_STATE}), 128'(2'b00));
    @(posedge CLK); #1;
  endtask

  task automatic check_err(input string name, input logic e);
    @(negedge CLK);
    check(name, 128'(ERR), 128'(e));
    @(posedge CLK); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset: all outputs low.
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("reset_outputs", 128'({OM_REN, OM_RADDR, OM_WEN, OM_WADDR, OM_WDATA, BUSY, Tile_Done, ERR, DBG_STATE}), 128'(0));
    @(posedge CLK); #1;
    RSTN = 1'b1;
    idle(2);

    // Clear: 16 zero writes to 0..15, BUSY for 16 cycles, no Tile_Done.
    do_clr(1'b0, 1'b0);
    check_err("err_after_clean_clear", 1'b0);

    // Overwrite tile: 4 rows back-to-back, lanes 1,2,3,4, done only after the 4th.
    for (int a = 0; a < 4; a++)
      send_row(4'(a), pack(16'd1, 16'd2, 16'd3, 16'd4), 1'b0, 3'd4, 1'b1, pack(16'd1, 16'd2, 16'd3, 16'd4));
    idle(3);

    // Accumulate: word 5 = {10,-3,7FFF,0}; add {1,3,1,-1} -> {11,0,8000,FFFF}.
    send_row(4'd5, pack(16'd10, 16'hFFFD, 16'h7FFF, 16'h0000), 1'b0, 3'd2, 1'b1,
             pack(16'd10, 16'hFFFD, 16'h7FFF, 16'h0000));
    idle(1);
    send_row(4'd5, pack(16'd1, 16'd3, 16'd1, 16'hFFFF), 1'b1, 3'd2, 1'b1,
             pack(16'd11, 16'h0000, 16'h8000, 16'hFFFF));
    idle(3);

    // Forwarding: back-to-back accumulate of 1 into word 2 from 0 -> 1 then 2.
    do_clr(1'b0, 1'b0);
    send_row(4'd2, pack(16'd1, 16'd1, 16'd1, 16'd1), 1'b1, 3'd2, 1'b1, pack(16'd1, 16'd1, 16'd1, 16'd1));
    send_row(4'd2, pack(16'd1, 16'd1, 16'd1, 16'd1), 1'b1, 3'd2, 1'b1, pack(16'd2, 16'd2, 16'd2, 16'd2));
    idle(3);

    // Partial tiles: ROWS=2 then ROWS=0 (4 rows), all back-to-back.
    send_row(4'd8, pack(16'h0101, 16'h0202, 16'h0303, 16'h0404), 1'b0, 3'd2, 1'b0, '0);
    send_row(4'd9, pack(16'h1111, 16'h2222, 16'h3333, 16'h4444), 1'b1, 3'd2, 1'b0, '0);
    for (int a = 10; a < 14; a++)
      send_row(4'(a), pack(16'(a), 16'h8000, 16'hFFFF, 16'(a * 3)), 1'b0, 3'd0, 1'b0, '0);
    idle(3);

    // Errors: rows during CLEAR are dropped; ERR sticks until the next CLR.
    do_clr(1'b0, 1'b1);
    check_err("err_after_drop_in_clear", 1'b1);
    idle(2);
    check_err("err_held", 1'b1);
    do_clr(1'b0, 1'b0);
    check_err("err_cleared_by_clr", 1'b0);
    do_clr(1'b1, 1'b0);
    check_err("err_row_in_clr_cycle", 1'b1);
    do_clr(1'b0, 1'b0);
    check_err("err_cleared_again", 1'b0);

    // Reset during a pending stage-1 write of a 1-row tile: no write, no done.
    PSUM_VALID = 1'b1; ODST = 4'd7; ACC = 1'b0; ROWS = 3'd1;
    PSUM_DATA = pack(16'd7, 16'd7, 16'd7, 16'd7);
    @(posedge CLK); #1;
    PSUM_VALID = 1'b0; RSTN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check("reset_midpipe_outputs", 128'({OM_REN, OM_RADDR, OM_WEN, OM_WADDR, OM_WDATA, BUSY, Tile_Done, ERR, DBG_STATE}), 128'(0));
      @(posedge CLK); #1;
    end
    RSTN = 1'b1;
    tb_cnt = 0;
    idle(3);

    // After reset: a single 1-row tile works normally.
    send_row(4'd7, pack(16'd5, 16'd6, 16'd7, 16'd8), 1'b0, 3'd1, 1'b0, '0);
    idle(4);

    check("writes_outstanding", 128'(exp_q.size()), 128'(0));
    check("tile_done_outstanding", 128'(td_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
